capture_sequencer: RTL
======================

// Module: capture_sequencer
// PURPOSE
//  Sequences the sampler: arms it per acquisition mode, generates the auto-mode force trigger, then
//  unrolls its circular sample memory from the oldest sample and streams one framed capture over a
//  valid/ready byte stream (to uart/display). Sits between user controls, sampler and sample RAM read port.
// PARAMETERS
//  SAMPLE_DEPTH  8        log2 of sample memory size; frame carries 2**SAMPLE_DEPTH samples
//  AUTO_TIMEOUT  1000000  clk_50mhz cycles after arming before auto mode forces a trigger
//  SYNC_BYTE     8'hA5    first byte of every frame
// PORTS
//  clk_50mhz    in   1   system clock
//  reset        in   1   synchronous, active-low
//  mode         in   2   0 STOP, 1 SINGLE, 2 NORMAL, 3 AUTO
//  rearm        in   1   1-cycle pulse; releases HOLD after a SINGLE capture
//  smp_activate out  1   to sampler activate
//  smp_done     in   1   from sampler done (level)
//  smp_offset   in   SAMPLE_DEPTH  trigger address from sampler
//  force_trig   out  1   to sampler force_trig
//  rd_addr      out  SAMPLE_DEPTH  sample RAM read address
//  rd_en        out  1   sample RAM read enable; rd_data valid the cycle after rd_en
//  rd_data      in   8   sample RAM read data
//  out_data     out  8   stream byte
//  out_valid    out  1   stream valid
//  out_ready    in   1   stream ready
//  out_last     out  1   high with final sample byte of frame
//  busy         out  1   high in every state except IDLE and HOLD
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): state IDLE; every output 0; timers, counters, latched offset cleared.
//    Reset mid-capture or mid-stream abandons the frame at once (no out_last, no trailing bytes).
//  - States: IDLE, ARM, WAIT_DONE, ABORT, SYNC, FETCH, LATCH, SEND, RELEASE, HOLD.
//  - IDLE: if mode!=STOP -> ARM. ARM: smp_activate=1, clear timer -> WAIT_DONE.
//  - WAIT_DONE: smp_activate held 1; timer counts each cycle, saturating. mode==AUTO and
//    timer>=AUTO_TIMEOUT -> force_trig=1 until smp_done seen. smp_done==1 -> latch smp_offset,
//    start=smp_offset+2**(SAMPLE_DEPTH-1)+1 (mod 2**SAMPLE_DEPTH), force_trig=0 -> SYNC.
//    mode==STOP while waiting -> ABORT.
//  - ABORT: force_trig=1 until smp_done, then -> RELEASE; no frame is emitted.
//  - SYNC: out_data=SYNC_BYTE, out_valid=1 until out_ready -> FETCH with idx=0.
//  - FETCH: rd_en=1, rd_addr=start+idx (wraps mod 2**SAMPLE_DEPTH) -> LATCH.
//  - LATCH: register rd_data into out_data -> SEND.
//  - SEND: out_valid=1, out_data stable, out_last=(idx==2**SAMPLE_DEPTH-1) until out_ready.
//    On handshake: last -> RELEASE; else idx+1 -> FETCH. 3 cycles/byte min; valid never drops early.
//  - Trigger sample appears at frame payload index 2**(SAMPLE_DEPTH-1)-1 (byte 128 after SYNC, D=8).
//  - RELEASE: smp_activate=0; wait smp_done==0, then mode SINGLE -> HOLD; NORMAL/AUTO -> ARM;
//    STOP -> IDLE. Mode is sampled only on leaving RELEASE, IDLE and HOLD.
//  - HOLD: rearm pulse -> ARM; mode==STOP -> IDLE; mode==NORMAL/AUTO -> ARM.
//  - mode changes during SYNC..SEND do not cut the frame short; they apply at RELEASE.
//  - smp_done originates from the slow sampler clock: treated as a level, registered once before use.
//  - out_valid, out_data, out_last, rd_en, smp_activate, force_trig all driven from registers.
// STRUCTURE
//  - Shared package osc_pkg: mode enum (MODE_STOP..MODE_AUTO), SYNC_BYTE default, state enum typedef.
//  - One sub-module: auto_trig_timer (saturating counter, clear/enable, expired flag).
//  - Address unroll and stream FSM stay in capture_sequencer.
// TESTING
//  1 SINGLE, sampler model done w/ offset=8'h10, out_ready=1 -> A5 then 256 bytes from addr 8'h91
//    upward wrapping, trigger byte (addr 10) at payload 127, out_last on 256th, then HOLD, busy=0.
//  2 AUTO, no real trigger, AUTO_TIMEOUT=100 -> force_trig rises exactly 100 cycles after
//    smp_activate, falls with done; frame follows; re-arms automatically.
//  3 out_ready toggled randomly during frame -> out_data/out_last stable while valid&~ready;
//    byte order and count unchanged; no duplicate or dropped byte.
//  4 NORMAL, switch mode to STOP during WAIT_DONE -> force_trig until done, no out_valid,
//    smp_activate drops, ends in IDLE.
//  5 reset low mid-SEND at byte 40 -> next cycle all outputs 0, IDLE; next frame starts with A5.
//  6 offset=8'hFF -> start addr 8'h80, rd_addr wraps FF->00 inside frame, 256 bytes exact.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared types for the oscilloscope capture path: acquisition modes,
// sequencer states and the default frame sync byte.
package osc_pkg;

    typedef enum logic [1:0] {
        MODE_STOP   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_NORMAL = 2'd2,
        MODE_AUTO   = 2'd3
    } mode_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_DONE,
        ST_ABORT,
        ST_SYNC,
        ST_FETCH,
        ST_LATCH,
        ST_SEND,
        ST_RELEASE,
        ST_HOLD
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // IDLE and HOLD are the only states in which the sequencer is not busy.
    function automatic logic is_quiescent(input state_e s);
        return (s == ST_IDLE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/auto_trig_timer.sv
// Saturating cycle counter for the auto-mode force trigger. expired is high
// during the cycle whose closing edge completes TIMEOUT enabled cycles.
module auto_trig_timer #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] THRESH = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q >= THRESH);

endmodule

// File: rtl/capture_sequencer.sv
// Arms the sampler per acquisition mode, forces a trigger in auto mode, then
// unrolls the circular sample memory oldest-first into one framed byte stream.
module capture_sequencer
    import osc_pkg::*;
#(
    parameter int unsigned SAMPLE_DEPTH = 8,
    parameter int unsigned AUTO_TIMEOUT = 1000000,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic                    rearm,
    output logic                    smp_activate,
    input  logic                    smp_done,
    input  logic [SAMPLE_DEPTH-1:0] smp_offset,
    output logic                    force_trig,
    output logic [SAMPLE_DEPTH-1:0] rd_addr,
    output logic                    rd_en,
    input  logic [7:0]              rd_data,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy
);

    // Oldest sample sits half a buffer plus one past the trigger address.
    localparam logic [SAMPLE_DEPTH-1:0] HALF_PLUS1 = SAMPLE_DEPTH'((1 << (SAMPLE_DEPTH - 1)) + 1);
    localparam logic [SAMPLE_DEPTH-1:0] LAST_IDX   = '1;
    localparam logic [SAMPLE_DEPTH-1:0] ONE        = SAMPLE_DEPTH'(1);

    mode_e mode_s;
    assign mode_s = mode_e'(mode);

    state_e                  state_q, state_d;
    logic                    done_q;
    logic [SAMPLE_DEPTH-1:0] start_q, start_d;
    logic [SAMPLE_DEPTH-1:0] idx_q, idx_d;
    logic [SAMPLE_DEPTH-1:0] rd_addr_q, rd_addr_d;
    logic                    rd_en_q, rd_en_d;
    logic [7:0]              out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    smp_activate_q, smp_activate_d;
    logic                    force_trig_q, force_trig_d;
    logic                    busy_q, busy_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    assign timer_clear = (state_q == ST_ARM);
    assign timer_en    = (state_q == ST_WAIT_DONE);

    auto_trig_timer #(
        .TIMEOUT(AUTO_TIMEOUT)
    ) u_auto_trig_timer (
        .clk    (clk_50mhz),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_comb begin
        state_d        = state_q;
        start_d        = start_q;
        idx_d          = idx_q;
        rd_addr_d      = rd_addr_q;
        rd_en_d        = 1'b0;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        smp_activate_d = smp_activate_q;
        force_trig_d   = force_trig_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mode_s != MODE_STOP) state_d = ST_ARM;
            end
            ST_ARM: begin
                smp_activate_d = 1'b1;
                state_d        = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_q) begin
                    start_d      = smp_offset + HALF_PLUS1;
                    force_trig_d = 1'b0;
                    out_data_d   = SYNC_BYTE;
                    out_valid_d  = 1'b1;
                    state_d      = ST_SYNC;
                end else if (mode_s == MODE_STOP) begin
                    force_trig_d = 1'b1;
                    state_d      = ST_ABORT;
                end else if ((mode_s == MODE_AUTO) && timer_expired) begin
                    force_trig_d = 1'b1;
                end
            end
            ST_ABORT: begin
                if (done_q) begin
                    force_trig_d   = 1'b0;
                    smp_activate_d = 1'b0;
                    state_d        = ST_RELEASE;
                end
            end
            ST_SYNC: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = '0;
                    rd_addr_d   = start_q;
                    rd_en_d     = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                out_data_d  = rd_data;
                out_valid_d = 1'b1;
                out_last_d  = (idx_q == LAST_IDX);
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        smp_activate_d = 1'b0;
                        state_d        = ST_RELEASE;
                    end else begin
                        idx_d     = idx_q + ONE;
                        rd_addr_d = start_q + idx_q + ONE;
                        rd_en_d   = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_RELEASE: begin
                if (!done_q) begin
                    unique case (mode_s)
                        MODE_STOP:   state_d = ST_IDLE;
                        MODE_SINGLE: state_d = ST_HOLD;
                        default:     state_d = ST_ARM;
                    endcase
                end
            end
            ST_HOLD: begin
                if (rearm || (mode_s == MODE_NORMAL) || (mode_s == MODE_AUTO)) begin
                    state_d = ST_ARM;
                end else if (mode_s == MODE_STOP) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = !is_quiescent(state_d);
    end

    // smp_done comes from the slow sampler clock; one register stage before use.
    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            done_q         <= 1'b0;
            start_q        <= '0;
            idx_q          <= '0;
            rd_addr_q      <= '0;
            rd_en_q        <= 1'b0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            smp_activate_q <= 1'b0;
            force_trig_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            done_q         <= smp_done;
            start_q        <= start_d;
            idx_q          <= idx_d;
            rd_addr_q      <= rd_addr_d;
            rd_en_q        <= rd_en_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            smp_activate_q <= smp_activate_d;
            force_trig_q   <= force_trig_d;
            busy_q         <= busy_d;
        end
    end

    assign smp_activate = smp_activate_q;
    assign force_trig   = force_trig_q;
    assign rd_addr      = rd_addr_q;
    assign rd_en        = rd_en_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;

endmodule
